sword_attack_ctrl: RTL and testbench
====================================

Name: sword_attack_ctrl

Overview:
- Sequences Link's sword-swing animation: on an attack press, steps through the sword sprite frames (frame_sel picks which sword ROM/palette pair is muxed in), then enforces a cooldown.
- Generates the shared 32x32 sprite ROM address from DrawX/DrawY and the sword position, and realigns the in-sprite flag to the ROM's 1-cycle read latency.
- Emits a pixel-accurate sword_on for the colour mapper; sits between the game-state logic and the sword ROM/palette instances.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- NUM_FRAMES, 3, animation frames per swing (max 4)
- HOLD_FRAMES, 4, vsync ticks each animation frame is shown
- COOLDOWN_FRAMES, 8, vsync ticks after a swing before a new attack is accepted

Ports:
- vga_clk  in  1  pixel clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- vsync  in  1  VGA vsync level; rising edge = frame tick
- attack  in  1  attack button level, already synchronised to vga_clk
- direction  in  2  facing direction: 0 left, 1 right, 2 up, 3 down
- link_x  in  10  Link top-left X
- link_y  in  10  Link top-left Y
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- blank  in  1  high = active video
- rom_q  in  3  palette index from the selected sword ROM (valid 1 cycle after address)
- rom_address  out  10  sprite ROM address
- frame_sel  out  2  animation frame index
- sword_on  out  1  draw sword pixel this cycle (aligned with rom_q)
- busy  out  1  high in SWING or COOLDOWN

Behaviour:
- Reset (async, active-high): state=IDLE, frame_sel=0, hold counter=0, cooldown counter=0, latched direction=0, sword_x=sword_y=0, sword_on=0, busy=0, vsync and attack edge registers cleared.
- Frame tick: vsync registered once; tick = vsync & ~vsync_q. Single-cycle pulse.
- Attack edge: att_rise = attack & ~attack_q. A level held from a previous swing never retriggers; the button must be released and pressed again.
- States:
  - IDLE: on att_rise, go to SWING next cycle. Set frame_sel=0 and hold=0. Latch direction. busy=1 from the following cycle.
  - SWING: on each tick, hold++. When hold==HOLD_FRAMES-1 at a tick, hold is set to 0 and frame_sel++. If frame_sel==NUM_FRAMES-1 at that point, go to COOLDOWN instead, with frame_sel kept and cooldown counter=0. Swing length = NUM_FRAMES*HOLD_FRAMES ticks.
  - COOLDOWN: on each tick, cnt++. At cnt==COOLDOWN_FRAMES-1 on a tick, go to IDLE, frame_sel=0, busy=0.
  - att_rise in SWING or COOLDOWN: ignored.
  - att_rise and tick in the same cycle in IDLE: start takes effect; that tick is not counted.
- Position: sword_x/sword_y update on every tick and on attack start. Values are 11-bit signed, computed from link_x/link_y and the latched direction:
  - left: x - SPRITE_W
  - right: x + SPRITE_W
  - up: y - SPRITE_H
  - down: y + SPRITE_H
  - the other axis is unchanged.
  - Position never changes mid-frame, so there is no tearing.
- Address, combinational:
  - dx = DrawX - sword_x and dy = DrawY - sword_y, both 11-bit signed.
  - in_box = 0<=dx<SPRITE_W and 0<=dy<SPRITE_H.
  - rom_address = dy*SPRITE_W + dx when in_box, else 0.
  - Negative or off-screen sword coordinates are clipped naturally; no wrap-around into the opposite screen edge.
- Pipeline: in_box, blank, and (state==SWING) are registered one stage. sword_on = in_box_q & blank_q & swing_q & (rom_q != 0). Index 0 is transparent. sword_on is a combinational AND of registered terms with rom_q. Latency from DrawX/DrawY to sword_on = 1 cycle.
- frame_sel only changes on tick cycles (blanking), so the ROM/palette mux is stable for the whole visible frame.
- Reset mid-swing: outputs return to reset values immediately; the next swing needs a fresh att_rise after reset release.

Test Plan:
- Reset then att_rise with direction=0, link=(100,200) -> busy=1 next cycle; frame_sel 0,1,2 across ticks 4 and 8; COOLDOWN after tick 12; busy=0 after tick 20; sword_x latched 68, sword_y 200.
- Swing active with sword at (68,200): drive DrawX=70, DrawY=203 with rom_q=5 on the next cycle -> rom_address=98; sword_on=1 one cycle later. Same point with rom_q=0 -> sword_on=0. blank=0 -> sword_on=0.
- Clipping: link_x=10, direction=left -> sword_x=-22. DrawX=0 gives rom_address=22 and sword_on possible. DrawX=630 -> in_box=0, rom_address=0.
- Retrigger: hold attack high through the whole swing and cooldown, plus extra presses during SWING and COOLDOWN -> no restart; swing length stays 12 ticks; returns to IDLE. A release+press in IDLE starts a new swing.
- Simultaneous att_rise and tick in IDLE -> SWING entered, hold=0; the first frame advance occurs 4 ticks later.
- Assert Reset while in SWING with frame_sel=1 -> frame_sel=0, busy=0, sword_on=0 asynchronously; no activity until a new press.

Source files
------------

// File: rtl/sword_attack_ctrl.sv
// rtl/sword_attack_ctrl.sv - sword swing sequencer, sprite ROM addressing and pixel gating
// Frames advance only on vsync ticks so the ROM/palette mux never changes mid-frame.
module sword_attack_ctrl #(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int NUM_FRAMES      = 3,
  parameter int HOLD_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic       attack,
  input  logic [1:0] direction,
  input  logic [9:0] link_x,
  input  logic [9:0] link_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [2:0] rom_q,
  output logic [9:0] rom_address,
  output logic [1:0] frame_sel,
  output logic       sword_on,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SWING    = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  logic [1:0]        state;
  logic              vsync_q;
  logic              attack_q;
  logic [HW-1:0]     hold;
  logic [CW-1:0]     cnt;
  logic [1:0]        dir_q;
  logic signed [10:0] sword_x;
  logic signed [10:0] sword_y;
  logic              in_box_q;
  logic              blank_q;
  logic              swing_q;

  logic              tick;
  logic              att_rise;
  logic              start;
  logic [1:0]        dir_use;
  logic signed [10:0] lx;
  logic signed [10:0] ly;
  logic signed [10:0] pos_x;
  logic signed [10:0] pos_y;
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              in_box;

  assign tick     = vsync & ~vsync_q;
  assign att_rise = attack & ~attack_q;
  assign start    = (state == IDLE) & att_rise;
  // The start cycle must place the sword using the direction being latched now.
  assign dir_use  = start ? direction : dir_q;
  assign lx       = $signed({1'b0, link_x});
  assign ly       = $signed({1'b0, link_y});

  always_comb begin
    pos_x = lx;
    pos_y = ly;
    case (dir_use)
      2'd0:    pos_x = lx - 11'(SPRITE_W);
      2'd1:    pos_x = lx + 11'(SPRITE_W);
      2'd2:    pos_y = ly - 11'(SPRITE_H);
      default: pos_y = ly + 11'(SPRITE_H);
    endcase
  end

  // Signed offsets: a negative dx sets bit 10, so off-left pixels never alias into the box.
  assign dx          = {1'b0, DrawX} - sword_x;
  assign dy          = {1'b0, DrawY} - sword_y;
  assign in_box      = ~dx[10] && (dx < 11'(SPRITE_W)) && ~dy[10] && (dy < 11'(SPRITE_H));
  assign rom_address = in_box ? 10'(dy * SPRITE_W + dx) : 10'd0;

  assign busy     = (state != IDLE);
  assign sword_on = in_box_q & blank_q & swing_q & (rom_q != 3'd0);

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      attack_q  <= 1'b0;
      hold      <= '0;
      cnt       <= '0;
      frame_sel <= 2'd0;
      dir_q     <= 2'd0;
      sword_x   <= '0;
      sword_y   <= '0;
      in_box_q  <= 1'b0;
      blank_q   <= 1'b0;
      swing_q   <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      attack_q <= attack;
      in_box_q <= in_box;
      blank_q  <= blank;
      swing_q  <= (state == SWING);
      if (start || tick) begin
        sword_x <= pos_x;
        sword_y <= pos_y;
      end
      case (state)
        IDLE: begin
          if (att_rise) begin
            state     <= SWING;
            frame_sel <= 2'd0;
            hold      <= '0;
            dir_q     <= direction;
          end
        end
        SWING: begin
          if (tick) begin
            if (hold == HW'(HOLD_FRAMES - 1)) begin
              hold <= '0;
              if (frame_sel == 2'(NUM_FRAMES - 1)) begin
                state <= COOLDOWN;
                cnt   <= '0;
              end else begin
                frame_sel <= frame_sel + 2'd1;
              end
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt == CW'(COOLDOWN_FRAMES - 1)) begin
              state     <= IDLE;
              frame_sel <= 2'd0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sword_attack_ctrl.sv
// tb/tb_sword_attack_ctrl.sv - directed vectors plus randomized run against a tick-count model
module tb_sword_attack_ctrl;

  localparam int SW_T = 3 * 4;   // swing ticks
  localparam int CD_T = 8;       // cooldown ticks

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vsync = 1'b0;
  logic       attack = 1'b0;
  logic [1:0] direction = 2'd0;
  logic [9:0] link_x = '0, link_y = '0, DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;
  logic [2:0] rom_q = '0;
  logic [9:0] rom_address;
  logic [1:0] frame_sel;
  logic       sword_on;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Model state: a swing is just a count of ticks since the press.
  bit m_active, m_vq, m_aq, m_ibq, m_bq, m_swq;
  int m_ticks, m_dir, m_sx, m_sy;

  sword_attack_ctrl dut (
    .vga_clk(vga_clk), .Reset(Reset), .vsync(vsync), .attack(attack),
    .direction(direction), .link_x(link_x), .link_y(link_y),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .rom_q(rom_q),
    .rom_address(rom_address), .frame_sel(frame_sel),
    .sword_on(sword_on), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x; int y; int q; int b; int exp_addr; int exp_on;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_vq = 0; m_aq = 0; m_ibq = 0; m_bq = 0; m_swq = 0;
    m_ticks = 0; m_dir = 0; m_sx = 0; m_sy = 0;
  endtask

  function automatic bit m_swing();
    return m_active && (m_ticks < SW_T);
  endfunction

  function automatic bit m_inbox();
    int dx = int'(DrawX) - m_sx;
    int dy = int'(DrawY) - m_sy;
    return (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
  endfunction

  function automatic int m_addr();
    if (!m_inbox()) return 0;
    return (int'(DrawY) - m_sy) * 32 + (int'(DrawX) - m_sx);
  endfunction

  function automatic int m_frame();
    if (!m_active) return 0;
    if (m_ticks < SW_T) return m_ticks / 4;
    return 2;
  endfunction

  task automatic model_update();
    bit tk, ar, st;
    if (Reset) return;
    tk = vsync && !m_vq;
    ar = attack && !m_aq;
    m_ibq = m_inbox();
    m_bq  = blank;
    m_swq = m_swing();
    st = !m_active && ar;
    if (st) m_dir = int'(direction);
    if (st || tk) begin
      m_sx = int'(link_x);
      m_sy = int'(link_y);
      case (m_dir)
        0: m_sx -= 32;
        1: m_sx += 32;
        2: m_sy -= 32;
        default: m_sy += 32;
      endcase
    end
    if (st) begin
      m_active = 1;
      m_ticks = 0;
    end else if (m_active && tk) begin
      m_ticks++;
      if (m_ticks == SW_T + CD_T) m_active = 0;
    end
    m_vq = vsync;
    m_aq = attack;
  endtask

  task automatic cyc();
    model_update();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; cyc();
      vsync = 1'b0; cyc();
    end
  endtask

  task automatic check_all();
    chk("rnd_rom_address", int'(rom_address), m_addr());
    chk("rnd_frame_sel", int'(frame_sel), m_frame());
    chk("rnd_busy", int'(busy), int'(m_active));
    chk("rnd_sword_on", int'(sword_on), int'(m_ibq && m_bq && m_swq && rom_q != 0));
  endtask

  vec_t vecs[7];

  initial begin
    int t;
    vecs[0] = '{x: 70, y: 203, q: 5, b: 1, exp_addr: 98,   exp_on: 1};
    vecs[1] = '{x: 70, y: 203, q: 0, b: 1, exp_addr: 98,   exp_on: 0};
    vecs[2] = '{x: 70, y: 203, q: 5, b: 0, exp_addr: 98,   exp_on: 0};
    vecs[3] = '{x: 67, y: 203, q: 5, b: 1, exp_addr: 0,    exp_on: 0};
    vecs[4] = '{x: 99, y: 231, q: 7, b: 1, exp_addr: 1023, exp_on: 1};
    vecs[5] = '{x: 100, y: 200, q: 3, b: 1, exp_addr: 0,   exp_on: 0};
    vecs[6] = '{x: 73, y: 201, q: 1, b: 1, exp_addr: 37,   exp_on: 1};

    model_reset();
    Reset = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1 Reset = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_sel", int'(frame_sel), 0);
    chk("reset_sword_on", int'(sword_on), 0);
    chk("reset_rom_address", int'(rom_address), 0);

    // Basic swing, left, link (100,200): sword at (68,200)
    link_x = 10'd100; link_y = 10'd200; direction = 2'd0; attack = 1'b1;
    cyc();
    chk("start_busy", int'(busy), 1);
    chk("start_frame_sel", int'(frame_sel), 0);
    attack = 1'b0;
    cyc();
    foreach (vecs[i]) begin
      DrawX = 10'(vecs[i].x); DrawY = 10'(vecs[i].y);
      blank = vecs[i].b[0]; rom_q = 3'd0;
      #1 chk($sformatf("vec%0d_addr", i), int'(rom_address), vecs[i].exp_addr);
      cyc();
      rom_q = 3'(vecs[i].q);
      #1 chk($sformatf("vec%0d_on", i), int'(sword_on), vecs[i].exp_on);
    end
    DrawX = 10'd70; DrawY = 10'd203; blank = 1'b1; rom_q = 3'd5;
    tick_n(3);  chk("tick3_frame", int'(frame_sel), 0);
    tick_n(1);  chk("tick4_frame", int'(frame_sel), 1);
    tick_n(4);  chk("tick8_frame", int'(frame_sel), 2);
    tick_n(3);  chk("tick11_on", int'(sword_on), 1);
    tick_n(1);
    chk("tick12_frame", int'(frame_sel), 2);
    chk("tick12_busy", int'(busy), 1);
    cyc();
    chk("cooldown_on", int'(sword_on), 0);
    tick_n(7);  chk("tick19_busy", int'(busy), 1);
    tick_n(1);
    chk("tick20_busy", int'(busy), 0);
    chk("tick20_frame", int'(frame_sel), 0);

    // Clipping: sword at (-22,100)
    link_x = 10'd10; link_y = 10'd100; direction = 2'd0; attack = 1'b1;
    cyc();
    attack = 1'b0; DrawX = 10'd0; DrawY = 10'd100; rom_q = 3'd0;
    #1 chk("clip_addr", int'(rom_address), 22);
    cyc();
    rom_q = 3'd4;
    #1 chk("clip_on", int'(sword_on), 1);
    DrawX = 10'd630;
    #1 chk("clip_far_addr", int'(rom_address), 0);
    cyc();
    chk("clip_far_on", int'(sword_on), 0);
    tick_n(20);
    chk("clip_done_busy", int'(busy), 0);

    // Retrigger attempts during swing and cooldown
    attack = 1'b1; cyc();
    tick_n(5);
    attack = 1'b0; cyc(); attack = 1'b1; cyc();
    tick_n(9);
    attack = 1'b0; cyc(); attack = 1'b1; cyc();
    tick_n(5);
    chk("retrig_t19_busy", int'(busy), 1);
    chk("retrig_t19_frame", int'(frame_sel), 2);
    tick_n(1);
    chk("retrig_t20_busy", int'(busy), 0);
    repeat (3) cyc();
    chk("held_no_restart", int'(busy), 0);
    attack = 1'b0; cyc(); attack = 1'b1; cyc();
    chk("repress_busy", int'(busy), 1);
    attack = 1'b0;
    tick_n(20);
    chk("repress_done", int'(busy), 0);

    // Press and tick in the same cycle: that tick is not counted
    attack = 1'b1; vsync = 1'b1; cyc();
    chk("simul_busy", int'(busy), 1);
    vsync = 1'b0; attack = 1'b0; cyc();
    tick_n(3);  chk("simul_t3_frame", int'(frame_sel), 0);
    tick_n(1);  chk("simul_t4_frame", int'(frame_sel), 1);

    // Asynchronous reset mid-swing
    DrawX = 10'd0; DrawY = 10'd100; blank = 1'b1; rom_q = 3'd5;
    cyc();
    chk("pre_reset_on", int'(sword_on), 1);
    #1 Reset = 1'b1;
    model_reset();
    #1;
    chk("async_frame", int'(frame_sel), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_on", int'(sword_on), 0);
    cyc();
    Reset = 1'b0;
    tick_n(2);
    chk("post_reset_idle", int'(busy), 0);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      if ($urandom_range(0, 15) == 0) attack = ~attack;
      if ($urandom_range(0, 7) == 0) direction = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        link_x = 10'($urandom_range(40, 600));
        link_y = 10'($urandom_range(40, 440));
      end
      if ($urandom_range(0, 1) == 0) begin
        t = m_sx + int'($urandom_range(0, 40)) - 4;
        DrawX = 10'((t < 0) ? 0 : t);
        t = m_sy + int'($urandom_range(0, 40)) - 4;
        DrawY = 10'((t < 0) ? 0 : t);
      end else begin
        DrawX = 10'($urandom_range(0, 639));
        DrawY = 10'($urandom_range(0, 479));
      end
      blank = 1'($urandom_range(0, 1));
      rom_q = 3'($urandom_range(0, 7));
      #1 check_all();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
